latch_write_sequencer: RTL
==========================

Name: latch_write_sequencer

Overview:
- Writer-side driver for a bank of transparent, level-enabled D latches with an active-low clear.
- Accepts words over a valid/ready handshake and presents each one on a stable data bus.
- Drives the latch enable as a timed strobe: programmable setup cycles, then a pulse of programmable width, then hold cycles. Data never changes while the enable is high or during the setup/hold windows.
- Sits between a synchronous producer and latch-based storage or output registers.

Parameters:
- WIDTH, 8: data word width.
- SETUP_CYC, 1: cycles data is stable before lat_en rises; legal range 0..2^CNT_W-1.
- PULSE_CYC, 2: cycles lat_en is high; legal range 1..2^CNT_W-1.
- HOLD_CYC, 1: cycles data is stable after lat_en falls; legal range 0..2^CNT_W-1.
- CNT_W, 4: width of the internal phase counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  word to write.
- in_valid  input  1  producer has a word.
- in_ready  output  1  sequencer can accept a word; high only in IDLE.
- lat_data  output  WIDTH  registered data bus to the latch D inputs.
- lat_en  output  1  registered latch enable strobe.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a write completes.

Behaviour:
- Reset: sampled at the rising clk edge while reset==0. It takes priority over all other activity.
  - Result: state=IDLE, counter=0, lat_data=0, lat_en=0, done=0.
  - in_ready=1 and busy=0 in the cycle after the reset edge.
  - Reset mid-operation (any state): lat_en drops at that edge. The write is abandoned and no done pulse is issued.
- States: IDLE, SETUP, STROBE, HOLD. The counter is reloaded on every state entry and decrements each cycle.
- IDLE:
  - in_ready=1.
  - Handshake completes when in_valid && in_ready at a rising edge. At that edge lat_data <= in_data.
  - Next state is SETUP if SETUP_CYC>0, otherwise STROBE.
  - Without a handshake, the FSM stays in IDLE and lat_data holds its last value.
- SETUP: lasts exactly SETUP_CYC cycles, then goes to STROBE. lat_en=0.
- STROBE: lasts exactly PULSE_CYC cycles.
  - lat_en is a flop output: set at the edge entering STROBE, cleared at the edge leaving it.
  - Next state is HOLD if HOLD_CYC>0, otherwise IDLE.
- HOLD: lasts exactly HOLD_CYC cycles, then goes to IDLE. lat_en=0.
- done: registered. It is 1 for exactly the first cycle of IDLE following a completed STROBE/HOLD, and 0 otherwise.
- lat_data: changes only at an accept edge. It is constant from accept through the end of HOLD and beyond, until the next accept.
- in_ready, busy: decoded from the state register, with no combinational path from in_valid.
- Back-to-back: in_ready is 1 in the done cycle, so a new word can be accepted there.
  - Throughput: one word per 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (5 at defaults).
  - With HOLD_CYC=0 the new lat_data appears at least one edge after lat_en falls.
- in_valid high while busy: ignored, nothing is captured. in_data may change freely while busy.
- Parameter values outside their legal ranges are unsupported. Simulation asserts on PULSE_CYC==0.

Test Plan:
1. Defaults. After reset, in_data=0xA5 and in_valid=1 for one cycle at edge E0.
   - lat_data=0xA5 from E0.
   - lat_en=1 for the 2 cycles after E0+1.
   - done=1 in the cycle after E0+4; in_ready=1 there.
2. Back-to-back. in_valid held at 1 with words 0x11, 0x22, 0x33.
   - One accept every 5 cycles.
   - lat_data never changes while lat_en=1 or during setup/hold.
   - Exactly 3 done pulses.
3. Busy stall. in_data is changed to 0xFF and in_valid is toggled while busy after accepting 0x3C.
   - lat_data stays 0x3C.
   - in_ready=0 until done.
   - No extra write occurs.
4. Reset mid-pulse. reset=0 at the first STROBE cycle.
   - Next edge: lat_en=0, lat_data=0, state IDLE, done=0.
   - After reset=1, a new word 0x5A completes normally.
5. Zero windows. SETUP_CYC=0, PULSE_CYC=1, HOLD_CYC=0, word 0x81.
   - lat_en is high for the 1 cycle right after accept.
   - done is in the following cycle; period is 2 cycles.
6. Idle quiescence. in_valid=0 for 20 cycles after reset.
   - lat_en=0, busy=0, done=0, lat_data=0 throughout.

Source files
------------

// File: rtl/latch_write_sequencer.sv
// Writer-side sequencer for a bank of level-enabled D latches: captures a word on a
// valid/ready handshake, then drives a setup / enable-pulse / hold strobe around stable data.
module latch_write_sequencer_chk #(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] lat_data,
  input logic             lat_en,
  input logic             in_ready,
  input logic             busy,
  input logic             done
);

  logic [WIDTH-1:0] lat_data_q_r;
  logic             busy_q_r;
  logic             reset_q_r;

  // Delayed copies of outputs used to check data stability across a write
  always_ff @(posedge clk) begin
    lat_data_q_r <= lat_data;
    busy_q_r     <= busy;
    reset_q_r    <= reset;
  end

  // Structural invariants of the sequencer outputs
  always_ff @(posedge clk) begin
    assert (PULSE_CYC != 0) else $error("latch_write_sequencer: PULSE_CYC must be nonzero");
    if (reset && reset_q_r) begin
      assert (in_ready != busy) else $error("latch_write_sequencer: in_ready/busy not complementary");
      assert (!(lat_en && !busy)) else $error("latch_write_sequencer: lat_en high while idle");
      assert (!(done && !in_ready)) else $error("latch_write_sequencer: done outside idle");
      // Data may only move at an accept edge, which can never follow a busy cycle.
      if (busy_q_r) begin
        assert (lat_data == lat_data_q_r) else $error("latch_write_sequencer: lat_data moved while busy");
      end
    end
  end

endmodule

module latch_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] lat_data,
  output logic             lat_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter reload values: a phase of N cycles loads N-1 and exits when it reaches zero.
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETUP_LD = (SETUP_CYC > 0) ? CNT_W'(SETUP_CYC - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PULSE_LD = (PULSE_CYC > 0) ? CNT_W'(PULSE_CYC - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_LD  = (HOLD_CYC > 0)  ? CNT_W'(HOLD_CYC - 1)  : {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [WIDTH-1:0] lat_data_r;
  logic             lat_en_r;
  logic             done_r;
  logic             accept_s;
  logic             finish_s;

  assign accept_s = (state_r == IDLE) && in_valid;

  // Next-state and counter reload logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (accept_s) begin
          if (SETUP_CYC > 0) begin
            state_s = SETUP;
            cnt_s   = SETUP_LD;
          end else begin
            state_s = STROBE;
            cnt_s   = PULSE_LD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = STROBE;
          cnt_s   = PULSE_LD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt_r == CNT_ZERO) begin
          if (HOLD_CYC > 0) begin
            state_s = HOLD;
            cnt_s   = HOLD_LD;
          end else begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // A write completes on the transition from STROBE or HOLD back to IDLE
  always_comb begin
    finish_s = 1'b0;
    if ((state_r == STROBE || state_r == HOLD) && state_s == IDLE) begin
      finish_s = 1'b1;
    end else begin
      finish_s = 1'b0;
    end
  end

  // State, counter and registered latch-side outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      lat_data_r <= {WIDTH{1'b0}};
      lat_en_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      lat_en_r <= (state_s == STROBE);
      done_r   <= finish_s;
      if (accept_s) begin
        lat_data_r <= in_data;
      end else begin
        lat_data_r <= lat_data_r;
      end
    end
  end

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);
  assign lat_data = lat_data_r;
  assign lat_en   = lat_en_r;
  assign done     = done_r;

  latch_write_sequencer_chk #(
    .WIDTH     (WIDTH),
    .PULSE_CYC (PULSE_CYC)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .lat_data (lat_data),
    .lat_en   (lat_en),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done)
  );

endmodule
